// File: rtl/ha_carry_resolver_pkg.sv
// Shared ALU definitions for the iterative half-adder carry resolver: widths and FSM states.
package ha_carry_resolver_pkg;

    localparam int ALU_WIDTH  = 32;
    // Pass counter must represent WIDTH+1, the worst-case number of half-adder passes.
    localparam int ALU_ITER_W = $clog2(ALU_WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } resolver_state_t;

endpackage

// File: rtl/ha_carry_resolver_if.sv
// Operand/result handshake bundle between the ALU operand latch, the resolver and the result mux.
interface ha_carry_resolver_if
    import ha_carry_resolver_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int ITER_W = $clog2(WIDTH + 2)
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_sum;
    logic              out_cout;
    logic [ITER_W-1:0] out_iters;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_iters
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_iters
    );

endinterface

// File: rtl/ha_carry_resolver_half_adder.sv
// Bitwise WIDTH-bit half adder: per-bit sum and carry, no carry propagation.
module ha_carry_resolver_half_adder
    import ha_carry_resolver_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/ha_carry_resolver.sv
// Iterative adder: feeds half-adder sum/carry back (a<=sum, b<=carry<<1) until no carry remains.
module ha_carry_resolver
    import ha_carry_resolver_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int ITER_W = $clog2(WIDTH + 2)
) (
    input  logic               clk,
    input  logic               rst,
    ha_carry_resolver_if.slave bus
);

    resolver_state_t   state_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              cout_r;
    logic [ITER_W-1:0] iters_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [WIDTH-1:0]  out_sum_r;
    logic              out_cout_r;
    logic [ITER_W-1:0] out_iters_r;
    logic [WIDTH-1:0]  sum_s;
    logic [WIDTH-1:0]  carry_s;

    ha_carry_resolver_half_adder #(.WIDTH(WIDTH)) u_half_adder (
        .a     (a_r),
        .b     (b_r),
        .sum   (sum_s),
        .carry (carry_s)
    );

    // FSM, operand registers, pass counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            iters_r     <= {ITER_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_sum_r   <= {WIDTH{1'b0}};
            out_cout_r  <= 1'b0;
            out_iters_r <= {ITER_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        a_r        <= bus.in_a;
                        b_r        <= bus.in_b;
                        cout_r     <= 1'b0;
                        iters_r    <= {ITER_W{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= ITER;
                    end
                end
                ITER: begin
                    // The carry leaving bit WIDTH-1 is dropped from b and survives only in cout.
                    iters_r <= iters_r + {{(ITER_W-1){1'b0}}, 1'b1};
                    cout_r  <= cout_r | carry_s[WIDTH-1];
                    a_r     <= sum_s;
                    b_r     <= {carry_s[WIDTH-2:0], 1'b0};
                    if (carry_s == {WIDTH{1'b0}}) begin
                        out_sum_r   <= sum_s;
                        out_cout_r  <= cout_r;
                        out_iters_r <= iters_r + {{(ITER_W-1){1'b0}}, 1'b1};
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // in_ready is forced low for the whole reset cycle, not just after the reset edge.
    assign bus.in_ready  = in_ready_r & ~rst;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = out_sum_r;
    assign bus.out_cout  = out_cout_r;
    assign bus.out_iters = out_iters_r;

endmodule
